multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 The block SHALL have ports op_a and op_b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port op_sel, input, 3 bits, with these encodings: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SLT (signed), 110 SLTU (unsigned), 111 MUL.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result registers hold an unconsumed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port result, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have ports zero_flag, carry_flag and ovf_flag, output, 1 bit each: registered flags paired with result.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; op_a, op_b and op_sel SHALL be captured on that edge only.
REQ-013 The FSM SHALL have three states: IDLE, BUSY (MUL iterating) and DONE (result held).
REQ-014 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready=1, and 0 in BUSY.
REQ-015 A non-MUL op accepted from IDLE or DONE SHALL write result and flags on the accepting edge and go to DONE; out_valid is then 1 in the next cycle (latency 1).
REQ-016 For a MUL accepted on an edge, the block SHALL enter BUSY, load a WIDTH-cycle counter and clear a 2*WIDTH-bit accumulator.
REQ-017 MUL SHALL use shift-add, one multiplier bit per edge, and run WIDTH edges.
REQ-018 On the WIDTH-th edge after MUL acceptance, MUL SHALL write the low WIDTH product bits to result and go to DONE (latency WIDTH+1).
REQ-019 In DONE, out_valid=1 and result/flags SHALL hold stable while out_ready=0.
REQ-020 In DONE with out_ready=1 and no new acceptance, the block SHALL go to IDLE and out_valid SHALL be 0 next cycle.
REQ-021 In DONE with out_ready=1 and a simultaneous non-MUL acceptance, the block SHALL stay in DONE with the new result (back-to-back, one result per cycle).
REQ-022 In DONE with out_ready=1 and a simultaneous MUL acceptance, the block SHALL go to BUSY with out_valid=0.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; SUB computes op_a + ~op_b + 1.
REQ-024 carry_flag SHALL equal the carry-out of bit WIDTH-1 for ADD, and for SUB SHALL be 1 when op_a >= op_b unsigned (no borrow).
REQ-025 For MUL, carry_flag SHALL be 1 when upper WIDTH product bits (unsigned) are nonzero; for AND/XOR/OR/SLT/SLTU it SHALL be 0.
REQ-026 For ADD, ovf_flag SHALL be 1 when sign(a)==sign(b) and sign(result)!=sign(a).
REQ-027 For SUB, ovf_flag SHALL be 1 when sign(a)!=sign(b) and sign(result)!=sign(a); for all other ops it SHALL be 0.
REQ-028 SLT/SLTU SHALL produce result = zero-extended 1-bit comparison (1 if a<b).
REQ-029 zero_flag SHALL be 1 exactly when the registered result is all zeros.
REQ-030 Unused op_sel values SHALL NOT exist (all eight encodings are defined); inputs outside an accepting edge SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL immediately force the FSM to IDLE and set out_valid, result, zero_flag, carry_flag, ovf_flag, counter and accumulator to 0, so in_ready=1.
REQ-032 Reset asserted mid-MUL or in DONE SHALL discard the operation; no result SHALL appear after reset release.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 With WIDTH=32, ADD 0x7FFFFFFF+0x00000001 SHALL give out_valid next cycle, result 0x80000000, ovf=1, carry=0, zero=0.
REQ-035 With WIDTH=32, SUB 5-5 SHALL give result 0, zero=1, carry=1, ovf=0; and SUB 3-5 SHALL give 0xFFFFFFFE, carry=0.
REQ-036 With WIDTH=32, SLT 0xFFFFFFFF vs 1 SHALL give 1, and SLTU with the same operands SHALL give 0.
REQ-037 With WIDTH=32, MUL 0x00010000*0x00010000 SHALL hold in_ready=0 for 32 cycles, then give out_valid with result 0, zero=1, carry=1.
REQ-038 With out_ready=0 for 5 cycles, result/flags SHALL hold stable; with out_ready=1 and continuous ADD requests, one result SHALL appear per cycle.
REQ-039 rst_n pulsed low at MUL cycle 10 SHALL give immediate IDLE with all outputs 0, in_ready=1, and no late out_valid.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB/logic/compare ops, shift-add MUL over
// WIDTH cycles, with a valid/ready handshake on both the request and result side.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [2*WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]       mplier_q;

  logic                   accept;
  logic                   last_step;
  logic [2*WIDTH-1:0]     acc_step;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]         sum, diff;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c, alu_v;

  // Two's-complement overflow of a + b: like-signed operands, result sign flips.
  function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Two's-complement overflow of a - b: unlike-signed operands, result sign differs from a.
  function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  assign a_s = op_a;
  assign b_s = op_b;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CNT_W'(1));
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle datapath for every op except MUL; SUB's carry-out means "no borrow".
  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH + 1)'(1);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ovf_add(op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = ovf_sub(op_a[WIDTH-1], op_b[WIDTH-1], diff[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  // Next-state and handshake outputs; DONE can accept only while the result is consumed.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (op_sel == OP_MUL) ? BUSY : DONE;
      end
      BUSY: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_d = (op_sel == OP_MUL) ? BUSY : DONE;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, multiplier iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (op_sel == OP_MUL) begin
          cnt_q    <= CNT_W'(WIDTH);
          acc_q    <= '0;
          mcand_q  <= {{WIDTH{1'b0}}, op_a};
          mplier_q <= op_b;
        end else begin
          result     <= alu_res;
          zero_flag  <= (alu_res == '0);
          carry_flag <= alu_c;
          ovf_flag   <= alu_v;
        end
      end else if (state_q == BUSY) begin
        cnt_q    <= cnt_q - CNT_W'(1);
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (last_step) begin
          result     <= acc_step[WIDTH-1:0];
          zero_flag  <= (acc_step[WIDTH-1:0] == '0);
          carry_flag <= |acc_step[2*WIDTH-1:WIDTH];
          ovf_flag   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu: directed spec vectors plus randomized ops
// checked against an arithmetic reference model.
module tb_multicycle_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   op_sel = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero_flag, carry_flag, ovf_flag;

  int total = 0;
  int passed = 0;
  int fails = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sel     (op_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {result, zero, carry, ovf} from plain integer arithmetic.
  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, full;
    logic [31:0] r;
    logic c, v;
    ua = a; ub = b; full = 0; c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'd0: begin
        full = ua + ub;
        r = full[31:0];
        c = full[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        c = (ua >= ub);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: begin
        full = ua * ub;
        r = full[31:0];
        c = (full[63:32] != 0);
      end
    endcase
    return {r, (r == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request (starting #1 after an edge), follow it to its result,
  // optionally stall the consumer, and leave out_ready=1 with the result in DONE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output int waited);
    logic [34:0] exp;
    int n, lat, busy_low;
    exp = model(op, a, b);
    out_ready = 1'b1;
    in_valid = 1'b1; op_sel = op; op_a = a; op_b = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    waited = n;
    chk("ready_wait_bound", {63'd0, (n < 200)}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_sel = 3'($urandom);
    if (stall > 0) out_ready = 1'b0;
    lat = 1; busy_low = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy_low++;
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, (op == 3'd7) ? W + 1 : 1);
    chk("busy_in_ready_low", busy_low, (op == 3'd7) ? W : 0);
    chk("result", result, exp[34:3]);
    chk("flags_zco", {zero_flag, carry_flag, ovf_flag}, exp[2:0]);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {out_valid, in_ready, result, zero_flag, carry_flag, ovf_flag},
          {1'b1, 1'b0, exp});
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int w, n;
    logic [2:0] op;

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", {out_valid, in_ready, result, zero_flag, carry_flag, ovf_flag},
        {1'b0, 1'b1, 32'h0, 3'b000});
    @(negedge clk); #2 rst_n = 1'b1;

    // Directed spec vectors; first request accepted on first edge after release
    run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, w);
    chk("first_accept_no_wait", w, 0);
    chk("add_ovf_vec", {result, zero_flag, carry_flag, ovf_flag}, {32'h8000_0000, 3'b001});
    run_op(3'd1, 32'd5, 32'd5, 0, w);
    chk("sub_eq_vec", {result, zero_flag, carry_flag, ovf_flag}, {32'h0, 3'b110});
    run_op(3'd1, 32'd3, 32'd5, 0, w);
    chk("sub_borrow_vec", {result, zero_flag, carry_flag, ovf_flag}, {32'hFFFF_FFFE, 3'b000});
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0, w);
    chk("slt_vec", {result, zero_flag, carry_flag, ovf_flag}, {32'h1, 3'b000});
    run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 0, w);
    chk("sltu_vec", {result, zero_flag, carry_flag, ovf_flag}, {32'h0, 3'b100});
    run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 0, w);
    chk("mul_vec", {result, zero_flag, carry_flag, ovf_flag}, {32'h0, 3'b110});
    run_op(3'd7, 32'd12345, 32'd678, 3, w);

    // Consumer stall of 5 cycles
    run_op(3'd0, $urandom, $urandom, 5, w);

    // DONE with out_ready and no request drops to IDLE
    @(posedge clk); #1;
    chk("done_to_idle", {out_valid, in_ready}, 2'b01);

    // Back-to-back ADDs: one result per cycle
    for (int i = 0; i < 8; i++) begin
      run_op(3'd0, pick(), pick(), 0, w);
      chk("b2b_no_wait", w, 0);
    end

    // Randomized mix of all ops, boundary operands and consumer stalls
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      run_op(op, pick(), pick(), $urandom_range(0, 2), w);
    end

    // Reset during MUL at cycle 10 discards the operation
    in_valid = 1'b1; op_sel = 3'd7; op_a = $urandom | 32'h1; op_b = $urandom | 32'h1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_mul", {out_valid, in_ready, result, zero_flag, carry_flag, ovf_flag},
        {1'b1 ^ 1'b1, 1'b1, 32'h0, 3'b000});
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("no_late_valid", n, 0);

    // Recovery after reset
    run_op(3'd3, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, w);
    chk("recover_no_wait", w, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
